hes_tx_serializer: RTL and testbench
====================================

Name: hes_tx_serializer

Overview:
Upstream feeder for the HES byte stream cipher. Accepts packed message words over a ready/valid interface and serialises them into one byte per cycle. For each byte it drives the cipher's valid, new_message, key and data inputs. It tracks message framing (SOM/EOM), latches the per-message key, and flags framing errors.

Parameters:
WORD_W, 32, input word width in bits; must be a multiple of 8, minimum 16
BYTES, WORD_W/8, derived; bytes per word (localparam)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
s_valid  in  1  input word valid
s_ready  out  1  block can accept a word this cycle
s_data  in  WORD_W  packed message bytes
s_bytes  in  $clog2(BYTES+1)  count of valid bytes in word, 1..BYTES; 0 is treated as BYTES
s_som  in  1  word is first of a message
s_eom  in  1  word is last of a message
cfg_key  in  8  key, sampled on acceptance of an SOM word
err_clr  in  1  clears sticky error flags
c_valid  out  1  byte strobe to cipher (valid_in)
c_new_message  out  1  first byte of message (new_message)
c_key  out  8  latched message key
c_data  out  8  byte to cipher (data_in)
busy  out  1  word currently being serialised
msg_done  out  1  one-cycle pulse with last byte of an EOM word
err_no_som  out  1  sticky: word arrived outside a message without SOM
err_no_eom  out  1  sticky: SOM arrived while a message was open

Behaviour:
- Reset (reset_n low, async): all outputs 0, c_key 0, state IDLE, in_msg 0, byte index 0. Reset mid-word discards the word and clears in_msg; nothing is emitted after release until a new word is accepted.
- Accept = s_valid && s_ready. s_ready = (state==IDLE) || (state==SHIFT && current byte is last of word). This gives back-to-back words with no bubble.
- States: IDLE -> SHIFT on accept. SHIFT stays in SHIFT while bytes remain. On the last byte, go to SHIFT if a new word is accepted that cycle, else IDLE.
- Latency: word accepted at edge N; its first byte appears on c_* registered at N+1. Bytes follow at consecutive cycles with no gaps. A word with k valid bytes yields exactly k c_valid cycles.
- Byte order: byte 0 = s_data[7:0] first, ascending. Bytes at index >= s_bytes are never emitted.
- c_new_message: 1 only with byte 0 of an accepted SOM word; 0 otherwise.
- Key: cfg_key is captured into the key register on SOM accept and drives c_key for the whole message. c_key is held between messages.
- in_msg: set on SOM accept, cleared on EOM accept. A word with SOM && EOM is a single-word message.
- Word without SOM while !in_msg: accepted and dropped (no c_valid), err_no_som set.
- SOM while in_msg: the new message starts normally (new_message, new key) and err_no_eom is set.
- msg_done pulses in the same cycle as the final c_valid of an EOM word.
- When c_valid=0, c_data, c_new_message and msg_done are 0.
- busy = (state==SHIFT).
- Errors: set-dominant over err_clr when both occur in the same cycle; otherwise err_clr clears them next edge.
- Handshake rule: s_data, s_bytes, s_som and s_eom are sampled only at accept. A held s_valid without ready must not be lost.

Optional Feature:
HES_TX_BSWAP_EN
- Defined: byte order reversed. The first byte is s_data[WORD_W-1 -: 8]. For a partial word (s_bytes=k) the top k bytes are emitted, most significant first.
- Undefined: little-endian order as in Behaviour. No other differences.

Decomposition:
- hes_pkg: BYTE_W=8, KEY_W=8, typedef enum {IDLE, SHIFT} hes_tx_state_t, typedef for the key byte. hes_pkg is shared with the cipher and any future output packer.
- No sub-module. The byte-select mux is inline.

Test Plan:
- Single word, WORD_W=32, s_data=32'h44332211, s_bytes=4, SOM+EOM, cfg_key=8'hA5 -> c_data 11,22,33,44 on 4 consecutive cycles; new_message only on 11; c_key=A5; msg_done with 44.
- Back-to-back: SOM word (4 bytes) then EOM word with s_bytes=2, s_valid held high -> 6 contiguous c_valid cycles; s_ready high only on byte-3 cycle and in IDLE; msg_done on 6th byte.
- Word with SOM=0 after reset -> no c_valid; err_no_som=1; err_clr pulse -> 0 next cycle.
- SOM mid-message with cfg_key=8'h3C -> new_message on its byte 0; c_key=3C; err_no_eom=1.
- reset_n low during byte 2 of a 4-byte word -> outputs 0 immediately; no further c_valid after release; s_ready=1.
- HES_TX_BSWAP_EN build: s_data=32'h44332211, s_bytes=3 -> c_data 44,33,22.

Source files
------------

// File: rtl/hes_pkg.sv
// -----------------------------------------------------------------------------
// hes_pkg
// Definitions shared by the HES byte stream cipher, the transmit serializer
// and any future output packer.
//   BYTE_W         : width of one stream byte
//   KEY_W          : width of the per-message cipher key
//   hes_tx_state_t : serializer states (IDLE, SHIFT)
//   hes_key_t      : key byte type
// -----------------------------------------------------------------------------
package hes_pkg;

  localparam int BYTE_W = 8;
  localparam int KEY_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } hes_tx_state_t;

  typedef logic [KEY_W-1:0] hes_key_t;

endpackage

// File: rtl/hes_tx_serializer.sv
// -----------------------------------------------------------------------------
// hes_tx_serializer
// Accepts packed message words over ready/valid and feeds them to the HES
// cipher one byte per cycle, tracking SOM/EOM framing, latching the
// per-message key and flagging framing errors.
//
// Build option: define HES_TX_BSWAP_EN to emit bytes most significant first
// (a partial word then yields its top s_bytes bytes). Undefined: byte 0 is
// s_data[7:0] and bytes go out in ascending order.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   s_valid/s_ready           input word handshake
//   s_data, s_bytes           packed bytes and valid byte count (0 = full)
//   s_som, s_eom              message framing of the input word
//   cfg_key                   key, captured when an SOM word is accepted
//   err_clr                   clears the sticky error flags
//   c_valid, c_new_message    byte strobe / first-byte-of-message to cipher
//   c_key, c_data             latched key and current byte to cipher
//   busy                      a word is being serialised
//   msg_done                  pulse with the last byte of an EOM word
//   err_no_som, err_no_eom    sticky framing error flags
// -----------------------------------------------------------------------------
module hes_tx_serializer
  import hes_pkg::*;
#(
  parameter int WORD_W = 32,
  localparam int BYTES = WORD_W / BYTE_W,
  localparam int CNT_W = $clog2(BYTES + 1),
  localparam int IDX_W = $clog2(BYTES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic [CNT_W-1:0]  s_bytes,
  input  logic              s_som,
  input  logic              s_eom,
  input  logic [KEY_W-1:0]  cfg_key,
  input  logic              err_clr,
  output logic              c_valid,
  output logic              c_new_message,
  output logic [KEY_W-1:0]  c_key,
  output logic [BYTE_W-1:0] c_data,
  output logic              busy,
  output logic              msg_done,
  output logic              err_no_som,
  output logic              err_no_eom
);

  hes_tx_state_t     state_q, state_d;
  logic              in_msg_q, in_msg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_idx_q, last_idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              som_q, som_d;
  logic              eom_q, eom_d;
  hes_key_t          key_q, key_d;
  logic              err_no_som_q, err_no_som_d;
  logic              err_no_eom_q, err_no_eom_d;

  logic              last_byte;
  logic              accept;
  logic              drop;
  logic              take;
  logic [CNT_W-1:0]  cnt_eff;
  logic [BYTE_W-1:0] byte_arr [BYTES];

  // Byte lanes in emission order; index 0 is the first byte sent.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
`ifdef HES_TX_BSWAP_EN
    assign byte_arr[gi] = word_q[WORD_W-1-gi*BYTE_W -: BYTE_W];
`else
    assign byte_arr[gi] = word_q[gi*BYTE_W +: BYTE_W];
`endif
  end

  // Ready while idle or while showing the final byte, so the next word
  // follows without a bubble.
  assign last_byte = (state_q == SHIFT) && (idx_q == last_idx_q);
  assign s_ready   = (state_q == IDLE) || last_byte;
  assign accept    = s_valid && s_ready;
  // A non-SOM word outside a message is consumed but never emitted.
  assign drop      = accept && !s_som && !in_msg_q;
  assign take      = accept && !drop;

  // Count of 0 (or anything beyond a full word) means a full word.
  always_comb begin
    cnt_eff = s_bytes;
    if (s_bytes == '0 || s_bytes > CNT_W'(BYTES)) begin
      cnt_eff = CNT_W'(BYTES);
    end
  end

  // State register (together with the datapath flops)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      in_msg_q     <= 1'b0;
      idx_q        <= '0;
      last_idx_q   <= '0;
      word_q       <= '0;
      som_q        <= 1'b0;
      eom_q        <= 1'b0;
      key_q        <= '0;
      err_no_som_q <= 1'b0;
      err_no_eom_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_msg_q     <= in_msg_d;
      idx_q        <= idx_d;
      last_idx_q   <= last_idx_d;
      word_q       <= word_d;
      som_q        <= som_d;
      eom_q        <= eom_d;
      key_q        <= key_d;
      err_no_som_q <= err_no_som_d;
      err_no_eom_q <= err_no_eom_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = SHIFT;
      SHIFT:   if (last_byte) state_d = take ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    in_msg_d   = in_msg_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    word_d     = word_q;
    som_d      = som_q;
    eom_d      = eom_q;
    key_d      = key_q;

    if (take) begin
      idx_d      = '0;
      last_idx_d = IDX_W'(cnt_eff - CNT_W'(1));
      word_d     = s_data;
      som_d      = s_som;
      eom_d      = s_eom;
      // EOM wins so an SOM+EOM word closes its own message.
      in_msg_d   = !s_eom;
      if (s_som) key_d = cfg_key;
    end else if (state_q == SHIFT && !last_byte) begin
      idx_d = idx_q + IDX_W'(1);
    end

    // New error events take priority over a clear in the same cycle.
    err_no_som_d = drop || (err_no_som_q && !err_clr);
    err_no_eom_d = (take && s_som && in_msg_q) || (err_no_eom_q && !err_clr);
  end

  // Output logic
  always_comb begin
    c_valid       = (state_q == SHIFT);
    busy          = (state_q == SHIFT);
    c_data        = c_valid ? byte_arr[idx_q] : '0;
    c_new_message = c_valid && som_q && (idx_q == '0);
    msg_done      = last_byte && eom_q;
    c_key         = key_q;
    err_no_som    = err_no_som_q;
    err_no_eom    = err_no_eom_q;
  end

endmodule

// File: tb/tb_hes_tx_serializer.sv
module tb_hes_tx_serializer;

  localparam int WORD_W = 32;
  localparam int BYTES  = 4;

  logic        clk;
  logic        reset_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [2:0]  s_bytes;
  logic        s_som;
  logic        s_eom;
  logic [7:0]  cfg_key;
  logic        err_clr;
  logic        c_valid;
  logic        c_new_message;
  logic [7:0]  c_key;
  logic [7:0]  c_data;
  logic        busy;
  logic        msg_done;
  logic        err_no_som;
  logic        err_no_eom;

  hes_tx_serializer #(.WORD_W(WORD_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_bytes(s_bytes),
    .s_som(s_som), .s_eom(s_eom), .cfg_key(cfg_key), .err_clr(err_clr),
    .c_valid(c_valid), .c_new_message(c_new_message), .c_key(c_key),
    .c_data(c_data), .busy(busy), .msg_done(msg_done),
    .err_no_som(err_no_som), .err_no_eom(err_no_eom)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int vcount = 0;   // c_valid cycles seen
  int dcount = 0;   // msg_done cycles seen

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Expected output is simply a queue of beats: the head is what is on the
  // cipher port now; the block can take a word when at most one beat is left.
  typedef struct {
    logic [7:0] data;
    logic       newm;
    logic       done;
  } beat_t;

  beat_t      mq[$];
  logic       m_in_msg = 1'b0;
  logic [7:0] m_key = 8'h00;
  logic       m_err_som = 1'b0;
  logic       m_err_eom = 1'b0;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input int i);
`ifdef HES_TX_BSWAP_EN
    return 8'((w >> (8 * (BYTES - 1 - i))) & 32'hFF);
`else
    return 8'((w >> (8 * i)) & 32'hFF);
`endif
  endfunction

  task automatic model_clear();
    mq.delete();
    m_in_msg  = 1'b0;
    m_key     = 8'h00;
    m_err_som = 1'b0;
    m_err_eom = 1'b0;
  endtask

  task automatic model_edge();
    logic acc, set_som, set_eom;
    int k;
    beat_t b;
    acc = s_valid && (mq.size() <= 1);
    set_som = 1'b0;
    set_eom = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      if (!s_som && !m_in_msg) begin
        set_som = 1'b1;
      end else begin
        if (s_som && m_in_msg) set_eom = 1'b1;
        if (s_som) m_key = cfg_key;
        k = (s_bytes == 0 || s_bytes > BYTES) ? BYTES : int'(s_bytes);
        for (int i = 0; i < k; i++) begin
          b.data = pick_byte(s_data, i);
          b.newm = s_som && (i == 0);
          b.done = s_eom && (i == k - 1);
          mq.push_back(b);
        end
        m_in_msg = !s_eom;
      end
    end
    m_err_som = set_som || (m_err_som && !err_clr);
    m_err_eom = set_eom || (m_err_eom && !err_clr);
  endtask

  // Compare process: outputs checked mid-cycle, model advanced on the edge.
  initial begin
    beat_t h;
    logic  hv;
    forever begin
      @(negedge clk);
      if (!reset_n) model_clear();
      hv = (mq.size() > 0);
      if (hv) h = mq[0];
      else begin h.data = 8'h00; h.newm = 1'b0; h.done = 1'b0; end
      chk("c_valid", 32'(c_valid), 32'(hv));
      chk("busy", 32'(busy), 32'(hv));
      chk("c_data", 32'(c_data), 32'(h.data));
      chk("c_new_message", 32'(c_new_message), 32'(h.newm));
      chk("msg_done", 32'(msg_done), 32'(h.done));
      chk("c_key", 32'(c_key), 32'(m_key));
      chk("err_no_som", 32'(err_no_som), 32'(m_err_som));
      chk("err_no_eom", 32'(err_no_eom), 32'(m_err_eom));
      if (reset_n) chk("s_ready", 32'(s_ready), 32'(mq.size() <= 1));
      if (c_valid === 1'b1) vcount++;
      if (msg_done === 1'b1) dcount++;
      @(posedge clk);
      if (!reset_n) model_clear();
      else model_edge();
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic idle_inputs();
    s_valid = 1'b0; s_data = '0; s_bytes = '0; s_som = 1'b0; s_eom = 1'b0;
    cfg_key = '0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Present a word from a negedge; return at the negedge after it is accepted.
  task automatic send(input logic [31:0] d, input logic [2:0] n, input logic som,
                      input logic eom, input logic [7:0] key);
    int waited;
    s_valid = 1'b1; s_data = d; s_bytes = n; s_som = som; s_eom = eom; cfg_key = key;
    waited = 0;
    while (!s_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk("send_timeout", 32'(waited), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  logic [7:0] exp4 [4];
  logic [7:0] exp3 [3];
  int v0, d0;

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1 chk("reset_c_valid", 32'(c_valid), 32'd0);
    chk("reset_c_key", 32'(c_key), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    #1 reset_n = 1'b1;
    @(negedge clk);

`ifdef HES_TX_BSWAP_EN
    exp4[0] = 8'h44; exp4[1] = 8'h33; exp4[2] = 8'h22; exp4[3] = 8'h11;
    exp3[0] = 8'h44; exp3[1] = 8'h33; exp3[2] = 8'h22;
`else
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
    exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
`endif

    // Single SOM+EOM word
    send(32'h44332211, 3'd4, 1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", 32'(c_data), 32'(exp4[i]));
      chk("t1_newm", 32'(c_new_message), 32'(i == 0));
      chk("t1_done", 32'(msg_done), 32'(i == 3));
      chk("t1_key", 32'(c_key), 32'hA5);
      @(negedge clk);
    end
    chk("t1_idle", 32'(c_valid), 32'd0);

    // Partial word, 3 bytes
    send(32'h44332211, 3'd3, 1'b1, 1'b1, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      chk("t6_data", 32'(c_data), 32'(exp3[i]));
      @(negedge clk);
    end
    chk("t6_idle", 32'(c_valid), 32'd0);

    // Back-to-back: 4-byte SOM word then 2-byte EOM word
    #3 v0 = vcount; d0 = dcount;
    send(32'hA3A2A1A0, 3'd4, 1'b1, 1'b0, 8'h21);
    send(32'hB3B2B1B0, 3'd2, 1'b0, 1'b1, 8'h00);
    repeat (8) @(negedge clk);
    #3 chk("t2_valid_cycles", 32'(vcount - v0), 32'd6);
    chk("t2_done_count", 32'(dcount - d0), 32'd1);

    // Word without SOM after reset
    do_reset();
    #3 v0 = vcount;
    send(32'hDEADBEEF, 3'd4, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    #3 chk("t3_no_valid", 32'(vcount - v0), 32'd0);
    chk("t3_err_set", 32'(err_no_som), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1 chk("t3_err_clr", 32'(err_no_som), 32'd0);

    // SOM while a message is open
    do_reset();
    send(32'h04030201, 3'd4, 1'b1, 1'b0, 8'h11);
    send(32'h14131211, 3'd4, 1'b1, 1'b1, 8'h3C);
    chk("t4_newm", 32'(c_new_message), 32'd1);
    chk("t4_key", 32'(c_key), 32'h3C);
    chk("t4_err_no_eom", 32'(err_no_eom), 32'd1);
    repeat (6) @(negedge clk);

    // Reset in the middle of a word
    do_reset();
    send(32'h44332211, 3'd4, 1'b1, 1'b1, 8'h77);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("t5_valid", 32'(c_valid), 32'd0);
    chk("t5_data", 32'(c_data), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1 v0 = vcount;
    repeat (6) @(negedge clk);
    #3 chk("t5_no_valid", 32'(vcount - v0), 32'd0);
    chk("t5_ready", 32'(s_ready), 32'd1);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      s_valid = ($urandom_range(0, 99) < 70);
      s_data  = $urandom();
      s_bytes = 3'($urandom_range(0, 7));
      s_som   = ($urandom_range(0, 99) < 35);
      s_eom   = ($urandom_range(0, 99) < 35);
      cfg_key = 8'($urandom());
      err_clr = ($urandom_range(0, 99) < 5);
    end
    @(negedge clk);
    idle_inputs();
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
